// File: rtl/mac_engine_vec.sv
// rtl/mac_engine_vec.sv - multi-lane signed MAC engine with streaming and job-accumulate modes
module mac_engine_vec #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 32,
    parameter int CNT_W     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_LANES*DATA_W-1:0]   a_tdata,
    input  logic                          a_tvalid,
    output logic                          a_tready,
    input  logic [NUM_LANES*DATA_W-1:0]   b_tdata,
    input  logic                          b_tvalid,
    output logic                          b_tready,
    input  logic [OUT_W-1:0]              c_tdata,
    input  logic                          c_tvalid,
    output logic                          c_tready,
    output logic [OUT_W-1:0]              d_tdata,
    output logic                          d_tvalid,
    input  logic                          d_tready,
    input  logic                          clear_i,
    input  logic                          enable_i,
    input  logic                          start_i,
    input  logic [1:0]                    mode_i,
    input  logic [CNT_W-1:0]              len_i,
    input  logic [$clog2(OUT_W)-1:0]      shift_i,
    input  logic                          round_i,
    input  logic                          sat_i,
    output logic [CNT_W-1:0]              cnt_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          sat_o
);

    localparam int SHIFT_W = $clog2(OUT_W);
    localparam int MUL_W   = 2 * DATA_W;
    localparam int PROD_W  = MUL_W + $clog2(NUM_LANES);
    localparam int GUARD_W = OUT_W + (1 << SHIFT_W) - 1;
    localparam int ACC_W   = ((PROD_W > GUARD_W) ? PROD_W : GUARD_W) + CNT_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD_C, ACC, OUT} state_e;

    state_e                    state, state_n;
    logic signed [PROD_W-1:0]  r_mult, lane_sum;
    logic                      r_mult_valid;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic                      live, simple_mode, ab_ok, fire_ab, fire_c, d_fire;
    logic signed [ACC_W-1:0]   post_in, rnd_add, rounded, shifted;
    logic                      sat_hi, sat_lo, sat_hit;

    always_comb begin : lane_reduce
        logic signed [MUL_W-1:0] a_ext, b_ext, prod;
        a_ext    = '0;
        b_ext    = '0;
        prod     = '0;
        lane_sum = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            a_ext    = MUL_W'($signed(a_tdata[k*DATA_W +: DATA_W]));
            b_ext    = MUL_W'($signed(b_tdata[k*DATA_W +: DATA_W]));
            prod     = a_ext * b_ext;
            lane_sum = lane_sum + PROD_W'(prod);
        end
    end

    // A pending reset or clear masks every handshake in the same cycle.
    assign live        = enable_i & ~rst_i & ~clear_i;
    assign simple_mode = (mode_i == 2'd0) || (mode_i == 2'd3);

    always_comb begin
        state_n  = state;
        ab_ok    = 1'b0;
        c_tready = 1'b0;
        d_tvalid = 1'b0;
        case (state)
            IDLE: begin
                if (simple_mode) begin
                    ab_ok    = live & (~r_mult_valid | d_tready);
                    d_tvalid = live & r_mult_valid;
                end else if (live && start_i) begin
                    if (mode_i == 2'd1)      state_n = LOAD_C;
                    else if (len_i == '0)    state_n = OUT;
                    else                     state_n = ACC;
                end
            end
            LOAD_C: begin
                c_tready = live;
                if (live && c_tvalid) state_n = (len_i == '0) ? OUT : ACC;
            end
            ACC: begin
                ab_ok = live & (cnt < len_i);
                if (live && cnt == len_i) state_n = OUT;
            end
            OUT: begin
                d_tvalid = live;
                if (live && d_tready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign fire_ab  = ab_ok & a_tvalid & b_tvalid;
    assign a_tready = fire_ab;
    assign b_tready = fire_ab;
    assign fire_c   = c_tready & c_tvalid;
    assign d_fire   = d_tvalid & d_tready;
    assign done_o   = (state == OUT) & d_fire;
    assign busy_o   = (state != IDLE) | r_mult_valid;
    assign cnt_o    = cnt;

    // Output path: round, arithmetic shift, then clamp or truncate to OUT_W.
    always_comb begin
        post_in = (state == OUT) ? acc : ACC_W'(r_mult);
        rnd_add = '0;
        if (round_i && shift_i != '0) rnd_add = ACC_W'(1) << (shift_i - 1'b1);
        rounded = post_in + rnd_add;
        shifted = rounded >>> shift_i;
        sat_hi  = shifted > SAT_MAX;
        sat_lo  = shifted < SAT_MIN;
        sat_hit = sat_i & (sat_hi | sat_lo);
        if (sat_i && sat_hi)      d_tdata = {1'b0, {(OUT_W-1){1'b1}}};
        else if (sat_i && sat_lo) d_tdata = {1'b1, {(OUT_W-1){1'b0}}};
        else                      d_tdata = shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= IDLE;
            r_mult       <= '0;
            r_mult_valid <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            sat_o        <= 1'b0;
        end else if (enable_i) begin
            state <= state_n;
            if (fire_ab) begin
                r_mult       <= lane_sum;
                r_mult_valid <= 1'b1;
            end else if (state == ACC || d_fire) begin
                r_mult_valid <= 1'b0;
            end
            if (state == IDLE && state_n != IDLE) begin
                acc <= '0;
                cnt <= '0;
            end else if (fire_c) begin
                acc <= ACC_W'($signed(c_tdata)) <<< shift_i;
                cnt <= '0;
            end else if (state == ACC) begin
                if (r_mult_valid) acc <= acc + ACC_W'(r_mult);
                if (fire_ab)      cnt <= cnt + 1'b1;
            end
            if (d_fire && sat_hit) sat_o <= 1'b1;
        end
    end

endmodule

// File: doc/mac_engine_vec.md
# mac_engine_vec

Parametrised multi-lane multiply-accumulate engine, the next generation of the HWPE MAC datapath. Each a/b beat carries NUM_LANES packed signed operands, and the block reduces their products to one sum per beat. It then either streams that sum (SIMPLE mode) or accumulates it over len_i beats on top of an optional c_i init (ACCUM / ACCUM_NOC modes). The output path applies a shift, optional round-to-nearest and optional saturation to OUT_W. The block sits between the HWPE streamer and the controller, in the same position as the scalar MAC engine.

## Interface
- NUM_LANES, 4: operand lanes per beat; power of 2, ≥1.
- DATA_W, 16: signed operand width per lane.
- OUT_W, 32: width of d_o and c_i.
- CNT_W, 8: width of len_i and cnt_o.
- Derived widths:
  - PROD_W = 2*DATA_W + $clog2(NUM_LANES): lane-sum width.
  - ACC_W = max(PROD_W, OUT_W + 2^$clog2(OUT_W) − 1) + CNT_W: accumulator width.
- clk_i  in  1  single clock; all logic is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- a_i  hwpe_stream_intf_stream.sink  NUM_LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- b_i  hwpe_stream_intf_stream.sink  NUM_LANES*DATA_W  same packing as a_i.
- c_i  hwpe_stream_intf_stream.sink  OUT_W  signed accumulator init.
- d_o  hwpe_stream_intf_stream.source  OUT_W  signed result.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- enable_i  in  1  0 freezes all state; all readys and d_o.valid are 0.
- start_i  in  1  launches one accumulate job (ACCUM modes only).
- mode_i  in  2  0=SIMPLE, 1=ACCUM, 2=ACCUM_NOC; 3 is reserved and behaves as SIMPLE.
- len_i  in  CNT_W  number of a/b beats per job.
- shift_i  in  $clog2(OUT_W)  c_i is shifted left by this amount; the output is shifted right by it.
- round_i  in  1  round-to-nearest on the right shift.
- sat_i  in  1  1 = clamp the result to OUT_W; 0 = truncate to the low OUT_W bits.
- cnt_o  out  CNT_W  a/b beats accepted in the current job.
- busy_o  out  1  state ≠ IDLE, or r_mult_valid.
- done_o  out  1  one-cycle pulse on the final d_o handshake of a job.
- sat_o  out  1  sticky; set when saturation clamped a result.

## Operation
- Datapath:
  - sum = Σ_k a[k]*b[k], signed, PROD_W bits.
  - The sum is registered in r_mult and flagged by r_mult_valid.
- Joint a/b handshake:
  - a_i.ready = b_i.ready = ab_ok & a_i.valid & b_i.valid, so neither stream is consumed alone.
  - fire_ab = a_i.ready.
- SIMPLE mode:
  - The FSM stays in IDLE.
  - ab_ok = enable_i & (~r_mult_valid | d_o.ready).
  - d_o.valid = enable_i & r_mult_valid; d_o carries post(r_mult).
- FSM states (ACCUM modes): IDLE, LOAD_C, ACC, OUT.
  - IDLE → LOAD_C: start_i, mode ACCUM.
  - IDLE → ACC: start_i, mode ACCUM_NOC; acc←0, cnt←0.
  - IDLE → OUT: start_i, mode ACCUM_NOC, len_i=0; acc←0.
  - LOAD_C: c_i.ready = enable_i.
    - On the c handshake: acc ← sign_ext(c_i.data) <<< shift_i, cnt←0.
    - Next state is ACC, or OUT if len_i=0.
  - ACC: ab_ok = enable_i & (cnt < len_i).
    - Each fire_ab increments cnt.
    - Each cycle with r_mult_valid: acc ← acc + r_mult, and r_mult_valid clears unless refilled.
    - Moves to OUT once cnt = len_i and the last r_mult has been added.
  - OUT: d_o.valid = enable_i; d_o.data = post(acc).
    - On d_o.ready: → IDLE and done_o pulses.
- post(x), computed in ACC_W bits:
  - Round: if round_i & shift_i>0, x ← x + (1 <<< (shift_i−1)).
  - Shift: y = x >>> shift_i.
  - Saturate: if sat_i and y is outside [−2^(OUT_W−1), 2^(OUT_W−1)−1], clamp y and set sat_o on the d_o handshake.
  - Truncate: if sat_i=0, output y[OUT_W−1:0].
- Control stability:
  - start_i outside IDLE, or while mode_i is SIMPLE, is ignored.
  - mode_i, len_i, shift_i, round_i and sat_i must be held stable from start until done_o. Behaviour is unspecified otherwise.
- Readys outside the above conditions:
  - c_i.ready is 0 outside LOAD_C.
  - a_i.ready and b_i.ready are 0 in IDLE, LOAD_C and OUT (ACCUM modes).

## Timing
- Reset (rst_i or clear_i, synchronous):
  - state=IDLE; r_mult, r_mult_valid, acc and cnt are 0.
  - All readys, d_o.valid, busy_o, done_o and sat_o are 0.
  - Reset takes priority over enable_i.
  - Reset mid-job aborts it; no output is produced.
- SIMPLE latency: d_o.valid 1 cycle after fire_ab; throughput 1 beat/cycle under continuous d_o.ready.
- ACCUM throughput: 1 beat/cycle.
- ACCUM latency: last fire_ab at cycle t → last add at t+1 → OUT at t+2, d_o.valid from t+2.
- ACCUM_NOC with len_i=0: start_i at t → d_o.valid at t+1, data = 0.
- d_o.data and d_o.valid are held stable while d_o.ready=0.
- enable_i=0 freezes the FSM, cnt, acc and r_mult. It drops d_o.valid, so hold enable_i high while a result is pending.
- Overflow: acc never wraps for len_i ≤ 2^CNT_W − 1 beats, from any c_i init and any shift_i.

## Test plan
- SIMPLE: a={1,2,3,4}, b={5,6,7,8}, shift_i=0 → d=70 one cycle after handshake; 8 back-to-back beats with d_o.ready=1 → 8 results with no bubbles.
- ACCUM: c=10, shift_i=2, len_i=3, each beat a={1,1,1,1}, b={2,2,2,2} → acc=40+24=64, d=16, one done_o pulse, cnt_o=3.
- Rounding in SIMPLE: a={3,0,0,0}, b={1,0,0,0}, shift_i=1:
  - round_i=1 → d=2; round_i=0 → d=1.
  - a={−3,0,0,0} with round_i=1 → d=−1.
- Saturation: all lanes a=b=0x7FFF, shift_i=0:
  - sat_i=1 → d=0x7FFFFFFF, sat_o=1 and it stays set.
  - sat_i=0 → d=0xFFFC0004, sat_o unchanged.
- Backpressure and edges:
  - d_o.ready=0 for 5 cycles in OUT → data and valid stable, a/b/c readys 0.
  - start_i in ACC is ignored.
  - ACCUM_NOC with len_i=0 → d=0 at t+1.
- Abort: clear_i (then rst_i) asserted after 2 of len_i=5 beats → IDLE next cycle, cnt_o=0, no d_o.valid, no done_o; the next job runs correctly.
